// File: rtl/fantasticfft_ifft8.sv
// 8-point inverse FFT, radix-2 DIT, fully pipelined (input reg + 3 butterfly stages).
// Each butterfly halves its result, so the frame leaves scaled by 1/8.

module fantasticfft_ifft8_bfly #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] ar,
    input  logic signed [WIDTH-1:0] ai,
    input  logic signed [WIDTH-1:0] br,
    input  logic signed [WIDTH-1:0] bi,
    output logic signed [WIDTH-1:0] sr,
    output logic signed [WIDTH-1:0] si,
    output logic signed [WIDTH-1:0] dr,
    output logic signed [WIDTH-1:0] di
);
    logic signed [WIDTH:0] sr_w, si_w, dr_w, di_w;

    always_comb begin
        sr_w = {ar[WIDTH-1], ar} + {br[WIDTH-1], br};
        si_w = {ai[WIDTH-1], ai} + {bi[WIDTH-1], bi};
        dr_w = {ar[WIDTH-1], ar} - {br[WIDTH-1], br};
        di_w = {ai[WIDTH-1], ai} - {bi[WIDTH-1], bi};
    end

    // dropping the LSB of the widened result is a floor shift by one
    assign sr = sr_w[WIDTH:1];
    assign si = si_w[WIDTH:1];
    assign dr = dr_w[WIDTH:1];
    assign di = di_w[WIDTH:1];
endmodule

module fantasticfft_ifft8 #(
    parameter int               WIDTH = 16,
    parameter int               FRAC  = 8,
    parameter logic [WIDTH-1:0] TWID  = 16'h00B5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  isValid,
    input  logic [7:0][WIDTH-1:0] yr,
    input  logic [7:0][WIDTH-1:0] yi,
    output logic                  resultValid,
    output logic [7:0][WIDTH-1:0] xr,
    output logic [7:0][WIDTH-1:0] xi
);
    localparam int STAGES = 3;
    localparam int PW     = 2*WIDTH + 1;

    logic [STAGES:0]        vld_pipe;
    logic [7:0][WIDTH-1:0]  s0r, s0i, s1r, s1i, s2r, s2i, s3r, s3i;
    logic [7:0][WIDTH-1:0]  c1r, c1i, c2r, c2i, c3r, c3i;
    logic [7:0][WIDTH-1:0]  t2r, t2i, t3r, t3i;
    logic signed [PW-1:0]   pa1, pb1, pa3, pb3;

    function automatic logic signed [PW-1:0] twmul(input logic [WIDTH-1:0] a);
        return PW'($signed(a)) * PW'($signed(TWID));
    endfunction

    function automatic logic [WIDTH-1:0] twscale(input logic signed [PW-1:0] p);
        return WIDTH'(p >>> FRAC);
    endfunction

    // stage 1: butterflies on bit-reversed pairs (0,4)(2,6)(1,5)(3,7)
    for (genvar g = 0; g < 4; g++) begin : g_st1
        fantasticfft_ifft8_bfly #(.WIDTH(WIDTH)) u_bf (
            .ar(s0r[2*g]), .ai(s0i[2*g]), .br(s0r[2*g+1]), .bi(s0i[2*g+1]),
            .sr(c1r[2*g]), .si(c1i[2*g]), .dr(c1r[2*g+1]), .di(c1i[2*g+1])
        );
    end

    // stage 2: legs 3 and 7 rotated by +j
    always_comb begin
        t2r    = s1r;
        t2i    = s1i;
        t2r[3] = -s1i[3];
        t2i[3] = s1r[3];
        t2r[7] = -s1i[7];
        t2i[7] = s1r[7];
    end

    for (genvar b = 0; b < 4; b++) begin : g_st2
        localparam int I = (b / 2) * 4 + (b % 2);
        fantasticfft_ifft8_bfly #(.WIDTH(WIDTH)) u_bf (
            .ar(t2r[I]),   .ai(t2i[I]),   .br(t2r[I+2]), .bi(t2i[I+2]),
            .sr(c2r[I]),   .si(c2i[I]),   .dr(c2r[I+2]), .di(c2i[I+2])
        );
    end

    // stage 3: W^0, TWID(1+j), +j, TWID(-1+j) on legs 4..7
    always_comb begin
        t3r    = s2r;
        t3i    = s2i;
        pa1    = twmul(s2r[5]);
        pb1    = twmul(s2i[5]);
        pa3    = twmul(s2r[7]);
        pb3    = twmul(s2i[7]);
        t3r[5] = twscale(pa1 - pb1);
        t3i[5] = twscale(pa1 + pb1);
        t3r[6] = -s2i[6];
        t3i[6] = s2r[6];
        t3r[7] = twscale(-(pa3 + pb3));
        t3i[7] = twscale(pa3 - pb3);
    end

    for (genvar i = 0; i < 4; i++) begin : g_st3
        fantasticfft_ifft8_bfly #(.WIDTH(WIDTH)) u_bf (
            .ar(t3r[i]),   .ai(t3i[i]),   .br(t3r[i+4]), .bi(t3i[i+4]),
            .sr(c3r[i]),   .si(c3i[i]),   .dr(c3r[i+4]), .di(c3i[i+4])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s0r <= '0; s0i <= '0;
            s1r <= '0; s1i <= '0;
            s2r <= '0; s2i <= '0;
            s3r <= '0; s3i <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], isValid};
            for (int i = 0; i < 8; i++) begin
                s0r[i] <= yr[{i[0], i[1], i[2]}];
                s0i[i] <= yi[{i[0], i[1], i[2]}];
            end
            s1r <= c1r; s1i <= c1i;
            s2r <= c2r; s2i <= c2i;
            s3r <= c3r; s3i <= c3i;
        end
    end

    assign resultValid = vld_pipe[STAGES];
    assign xr          = s3r;
    assign xi          = s3i;
endmodule

// File: tb/tb_fantasticfft_ifft8.sv
// Directed bench for fantasticfft_ifft8: stimulus pushes expected frames,
// a negedge monitor pops and compares whenever resultValid is high.

module tb_fantasticfft_ifft8;
    typedef logic [7:0][15:0] frame_t;
    typedef struct {
        frame_t r;
        frame_t i;
        int     tol;
        int     cyc;
        string  name;
    } exp_t;

    logic   clk = 0;
    logic   rst_n;
    logic   isValid;
    frame_t yr, yi, xr, xi;
    logic   resultValid;

    int     cyc = 0;
    int     n_chk = 0;
    int     n_fail = 0;
    exp_t   sbq[$];

    fantasticfft_ifft8 dut (
        .clk(clk), .rst_n(rst_n), .isValid(isValid), .yr(yr), .yi(yi),
        .resultValid(resultValid), .xr(xr), .xi(xi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: compare each sample against the head of the scoreboard
    always @(negedge clk) begin
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            n_chk++; n_fail++;
            $display("FAIL %s_missing: no resultValid by cycle %0d, expected at %0d", sbq[0].name, cyc, sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (resultValid !== 1'b0) begin
            n_chk++;
            if (resultValid !== 1'b1 || sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: resultValid=%b with no frame pending (cycle %0d)", resultValid, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s_latency: valid at cycle %0d, expected %0d", e.name, cyc, e.cyc);
                end
                for (int k = 0; k < 8; k++) begin
                    int dr, di;
                    dr = int'($signed(xr[k])) - int'($signed(e.r[k]));
                    di = int'($signed(xi[k])) - int'($signed(e.i[k]));
                    n_chk += 2;
                    if (dr > e.tol || dr < -e.tol) begin
                        n_fail++;
                        $display("FAIL %s_xr[%0d]: got %h, expected %h (+/-%0d)", e.name, k, xr[k], e.r[k], e.tol);
                    end
                    if (di > e.tol || di < -e.tol) begin
                        n_fail++;
                        $display("FAIL %s_xi[%0d]: got %h, expected %h (+/-%0d)", e.name, k, xi[k], e.i[k], e.tol);
                    end
                end
            end
        end
    end

    task automatic send(input frame_t r, input frame_t i, input frame_t er, input frame_t ei,
                        input int tol, input string name);
        exp_t e;
        @(posedge clk); #1;
        isValid = 1'b1; yr = r; yi = i;
        e.r = er; e.i = ei; e.tol = tol; e.name = name;
        e.cyc = cyc + 4;   // sampled on the next edge, presented three edges later
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            isValid = 1'b0;
        end
    endtask

    frame_t imp_r, dc_r, dcn_r, rt_r, rt_i, zero, ones_x, onesn_x, rt_x, impx_r;

    initial begin
        zero = '0;
        for (int k = 0; k < 8; k++) begin
            imp_r[k]   = 16'h0100;
            ones_x[k]  = 16'h0100;
            onesn_x[k] = 16'hFF00;
            rt_x[k]    = 16'((k + 1) * 256);
        end
        impx_r = '0;  impx_r[0] = 16'h0100;
        dc_r   = '0;  dc_r[0]   = 16'h0800;
        dcn_r  = '0;  dcn_r[0]  = 16'hF800;
        rt_r = '0; rt_i = '0;
        rt_r[0] = 16'h2400;
        for (int k = 1; k < 8; k++) rt_r[k] = 16'hFC00;
        rt_i[1] = 16'h09A8; rt_i[2] = 16'h0400; rt_i[3] = 16'h01A8;
        rt_i[5] = 16'hFE58; rt_i[6] = 16'hFC00; rt_i[7] = 16'hF658;

        rst_n = 1'b0; isValid = 1'b0; yr = '0; yi = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 256'(resultValid), 256'(0));
        chk("reset_xr", 256'(xr), 256'(0));
        chk("reset_xi", 256'(xi), 256'(0));
        rst_n = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_valid", 256'(resultValid), 256'(0));
            chk("idle_data", 256'({xr, xi}), 256'(0));
        end

        send(imp_r, zero, impx_r, zero, 0, "impulse");  idle(6);
        send(dc_r,  zero, ones_x, zero, 0, "dc_pos");   idle(6);
        send(dcn_r, zero, onesn_x, zero, 0, "dc_neg");  idle(6);
        send(rt_r,  rt_i, rt_x,   zero, 3, "roundtrip"); idle(6);

        send(imp_r, zero, impx_r, zero, 0, "b2b_impulse");
        send(dc_r,  zero, ones_x, zero, 0, "b2b_dc");
        send(rt_r,  rt_i, rt_x,   zero, 3, "b2b_roundtrip");
        idle(8);

        // frame at edge N, reset sampled at edge N+1: nothing may emerge
        @(posedge clk); #1;
        isValid = 1'b1; yr = rt_r; yi = rt_i;
        @(posedge clk); #1;
        isValid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_valid", 256'(resultValid), 256'(0));
        chk("midrst_xr", 256'(xr), 256'(0));
        chk("midrst_xi", 256'(xi), 256'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("midrst_quiet", 256'(resultValid), 256'(0));
        end

        // isValid alongside rst_n=0 is dropped
        rst_n = 1'b0; isValid = 1'b1; yr = dc_r; yi = zero;
        @(posedge clk); #1;
        rst_n = 1'b1; isValid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("rst_valid_ignored", 256'(resultValid), 256'(0));
        end

        // last directed frame after reset recovery
        send(dcn_r, zero, onesn_x, zero, 0, "post_reset_dc"); idle(1);

        for (int c = 0; c < 20 && sbq.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL drain: %0d frames never emerged", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
